// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-receiver to frame-controller link plus register-write side.
// The slave view belongs to the frame controller; the master view drives received bytes.
interface uart_rx_frame_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] err_cnt;
  logic       busy;

  modport master (
    output rx_data, rx_valid,
    input  wr_en, wr_addr, wr_data, frame_ok, frame_err, err_cnt, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output wr_en, wr_addr, wr_data, frame_ok, frame_err, err_cnt, busy
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller: assembles SYNC/CMD/DATA/CHK byte frames from the serial
// receiver into single-cycle register writes; drops and counts bad or stalled frames.
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 156250
) (
  input logic               clk,
  input logic               rst,
  uart_rx_frame_ctrl_if.slave bus
);

  localparam int unsigned            TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0]     TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    GET_CMD,
    GET_DATA,
    GET_CHK
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [7:0]         cmd_q;
  logic [7:0]         data_q;

  logic       is_sync;
  logic       timed_out;
  logic       bad_cmd;
  logic       bad_chk;
  logic       drop;
  logic [7:0] chk_sum;

  // Decide this cycle's frame drop; a consumed byte always beats an expired timer.
  always_comb begin
    is_sync   = (bus.rx_data == SYNC_BYTE);
    chk_sum   = cmd_q + data_q;
    timed_out = (state != IDLE) && !bus.rx_valid && (timer == '0);
    bad_cmd   = (state == GET_CMD) && bus.rx_valid && !is_sync && (bus.rx_data[7:4] != 4'h1);
    bad_chk   = (state == GET_CHK) && bus.rx_valid && (bus.rx_data != chk_sum);
    drop      = timed_out | bad_cmd | bad_chk;
  end

  // Frame FSM with inter-byte timer, registered strobes and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      cmd_q         <= '0;
      data_q        <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.frame_ok  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.err_cnt   <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.wr_en     <= 1'b0;
      bus.frame_ok  <= 1'b0;
      bus.frame_err <= drop;
      if (drop && (bus.err_cnt != '1)) begin
        bus.err_cnt <= bus.err_cnt + 8'd1;
      end

      if (drop) begin
        state    <= IDLE;
        busy_clr();
      end else if (bus.rx_valid) begin
        case (state)
          IDLE: begin
            if (is_sync) begin
              state    <= GET_CMD;
              timer    <= TIMER_LOAD;
              bus.busy <= 1'b1;
            end
          end
          GET_CMD: begin
            timer <= TIMER_LOAD;
            if (!is_sync) begin
              cmd_q <= bus.rx_data;
              state <= GET_DATA;
            end
          end
          GET_DATA: begin
            data_q <= bus.rx_data;
            timer  <= TIMER_LOAD;
            state  <= GET_CHK;
          end
          GET_CHK: begin
            bus.wr_en    <= 1'b1;
            bus.frame_ok <= 1'b1;
            bus.wr_addr  <= cmd_q[3:0];
            bus.wr_data  <= data_q;
            state        <= IDLE;
            busy_clr();
          end
          default: begin
            state <= IDLE;
            busy_clr();
          end
        endcase
      end else if (state != IDLE) begin
        // Non-zero here: a zero timer without rx_valid is handled as a drop above.
        timer <= timer - 1'b1;
      end
    end
  end

  // Shared return-to-idle bookkeeping; only called from the clocked block.
  task automatic busy_clr();
    bus.busy <= 1'b0;
    timer    <= '0;
  endtask

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frame scenarios followed by random
// byte traffic, every cycle checked against a queue-based frame model.
module tb_uart_rx_frame_ctrl;

  localparam int unsigned T = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_frame_ctrl_if bus ();

  uart_rx_frame_ctrl #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: bytes of the frame collected so far, plus idle-gap count.
  logic [7:0]  fr[$];
  int unsigned gap;
  logic [7:0]  m_cnt;
  logic [3:0]  m_addr;
  logic [7:0]  m_data;
  logic        m_wr, m_ok, m_err, m_busy;

  function automatic void model_reset();
    fr.delete();
    gap    = 0;
    m_cnt  = 8'h00;
    m_addr = 4'h0;
    m_data = 8'h00;
    m_wr   = 1'b0;
    m_ok   = 1'b0;
    m_err  = 1'b0;
    m_busy = 1'b0;
  endfunction

  function automatic void model_cycle(logic v, logic [7:0] d);
    logic [7:0] c;
    logic [7:0] s;
    m_wr  = 1'b0;
    m_ok  = 1'b0;
    m_err = 1'b0;
    if (v) begin
      gap = 0;
      if (fr.size() == 0) begin
        if (d == 8'hA5) fr.push_back(d);
      end else if (fr.size() == 1) begin
        if (d != 8'hA5) begin
          if (d[7:4] != 4'h1) begin
            m_err = 1'b1;
            fr.delete();
          end else begin
            fr.push_back(d);
          end
        end
      end else if (fr.size() == 2) begin
        fr.push_back(d);
      end else begin
        c = fr[1];
        s = fr[1] + fr[2];
        if (d == s) begin
          m_wr   = 1'b1;
          m_ok   = 1'b1;
          m_addr = c[3:0];
          m_data = fr[2];
        end else begin
          m_err = 1'b1;
        end
        fr.delete();
      end
    end else if (fr.size() != 0) begin
      gap++;
      // Last byte in cycle N: the (T+1)th silent cycle is N+T+1, pulse visible at N+T+2.
      if (gap > T) begin
        m_err = 1'b1;
        fr.delete();
      end
    end
    if (m_err && (m_cnt != 8'hFF)) m_cnt = m_cnt + 8'd1;
    m_busy = (fr.size() != 0);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string p);
    chk({p, "_wr_en"},     32'(bus.wr_en),     32'(m_wr));
    chk({p, "_frame_ok"},  32'(bus.frame_ok),  32'(m_ok));
    chk({p, "_frame_err"}, 32'(bus.frame_err), 32'(m_err));
    chk({p, "_err_cnt"},   32'(bus.err_cnt),   32'(m_cnt));
    chk({p, "_busy"},      32'(bus.busy),      32'(m_busy));
    chk({p, "_wr_addr"},   32'(bus.wr_addr),   32'(m_addr));
    chk({p, "_wr_data"},   32'(bus.wr_data),   32'(m_data));
  endtask

  task automatic step(logic v, logic [7:0] d);
    @(negedge clk);
    rst          = 1'b0;
    bus.rx_valid = v;
    bus.rx_data  = v ? d : 8'($urandom);
    model_cycle(v, d);
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    model_reset();
    @(posedge clk);
    #1;
    check_all("rst");
  endtask

  task automatic idle(int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send4(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3,
                       int unsigned maxgap);
    idle($urandom_range(0, maxgap)); step(1'b1, b0);
    idle($urandom_range(0, maxgap)); step(1'b1, b1);
    idle($urandom_range(0, maxgap)); step(1'b1, b2);
    idle($urandom_range(0, maxgap)); step(1'b1, b3);
  endtask

  initial begin
    logic [7:0] c, d;
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    do_reset();
    chk("reset_busy",    32'(bus.busy),    32'd0);
    chk("reset_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("reset_wr_addr", 32'(bus.wr_addr), 32'd0);

    // 1: good frame
    send4(8'hA5, 8'h13, 8'h5C, 8'h6F, 0);
    chk("t1_wr_en",   32'(bus.wr_en),    32'd1);
    chk("t1_ok",      32'(bus.frame_ok), 32'd1);
    chk("t1_addr",    32'(bus.wr_addr),  32'h3);
    chk("t1_data",    32'(bus.wr_data),  32'h5C);
    chk("t1_err_cnt", 32'(bus.err_cnt),  32'd0);

    // 2: bad checksum
    send4(8'hA5, 8'h13, 8'h5C, 8'h00, 0);
    chk("t2_err",     32'(bus.frame_err), 32'd1);
    chk("t2_wr_en",   32'(bus.wr_en),     32'd0);
    chk("t2_err_cnt", 32'(bus.err_cnt),   32'd1);
    chk("t2_addr",    32'(bus.wr_addr),   32'h3);
    chk("t2_data",    32'(bus.wr_data),   32'h5C);

    // 3: bad command, then resync on repeated SYNC
    step(1'b1, 8'hA5);
    step(1'b1, 8'h27);
    chk("t3_err", 32'(bus.frame_err), 32'd1);
    step(1'b1, 8'hA5);
    step(1'b1, 8'hA5);
    step(1'b1, 8'h1F);
    step(1'b1, 8'h01);
    step(1'b1, 8'h20);
    chk("t3_wr_en",   32'(bus.wr_en),   32'd1);
    chk("t3_addr",    32'(bus.wr_addr), 32'hF);
    chk("t3_data",    32'(bus.wr_data), 32'h01);
    chk("t3_err_cnt", 32'(bus.err_cnt), 32'd2);

    // 4: timeout boundary
    idle(3);
    step(1'b1, 8'hA5);
    idle(T);
    chk("t4_no_err_early", 32'(bus.frame_err), 32'd0);
    chk("t4_busy_early",   32'(bus.busy),      32'd1);
    idle(1);
    chk("t4_err_at_n102",  32'(bus.frame_err), 32'd1);
    chk("t4_busy_drop",    32'(bus.busy),      32'd0);
    step(1'b1, 8'hA5);
    idle(T);
    step(1'b1, 8'h13);
    chk("t4_late_byte_err", 32'(bus.frame_err), 32'd0);
    chk("t4_late_busy",     32'(bus.busy),      32'd1);
    step(1'b1, 8'h5C);
    step(1'b1, 8'h6F);
    chk("t4_late_wr_en", 32'(bus.wr_en), 32'd1);

    // 5: saturation, then reset
    for (int i = 0; i < 300; i++) send4(8'hA5, 8'h13, 8'h5C, 8'h00, 0);
    chk("t5_sat", 32'(bus.err_cnt), 32'hFF);
    do_reset();
    chk("t5_rst_cnt",  32'(bus.err_cnt), 32'd0);
    chk("t5_rst_addr", 32'(bus.wr_addr), 32'd0);
    chk("t5_rst_data", 32'(bus.wr_data), 32'd0);

    // 6: reset mid-frame, stray bytes in idle
    step(1'b1, 8'hA5);
    step(1'b1, 8'h13);
    do_reset();
    step(1'b1, 8'h5C);
    step(1'b1, 8'h6F);
    chk("t6_wr_en", 32'(bus.wr_en),     32'd0);
    chk("t6_err",   32'(bus.frame_err), 32'd0);
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h13);
    chk("t6_busy",    32'(bus.busy),    32'd0);
    chk("t6_err_cnt", 32'(bus.err_cnt), 32'd0);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      c = {4'h1, 4'($urandom)};
      d = 8'($urandom);
      case ($urandom_range(0, 7))
        0:       step(1'b1, 8'($urandom));
        1, 2:    send4(8'hA5, c, d, c + d, 3);
        3:       send4(8'hA5, c, d, 8'($urandom), 2);
        4:       begin step(1'b1, 8'hA5); step(1'b1, 8'($urandom)); end
        5:       begin step(1'b1, 8'hA5); step(1'b1, c); idle($urandom_range(T - 5, T + 5)); end
        6:       idle($urandom_range(0, 8));
        default: begin
          if ($urandom_range(0, 3) == 0) do_reset();
          else send4(8'hA5, c, d, c + d, 0);
        end
      endcase
    end
    idle(T + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
